mux_n_skid: RTL



---
 rtl/mux_n_skid.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mux_n_skid.sv
// N-input data selector with a registered output stage and a 2-entry skid buffer.
// Out-of-range select codes pick DEFAULT_IDX and raise out_err with the beat.
module mux_n_skid #(
  parameter int DATA_W      = 16,
  parameter int N_IN        = 3,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_IDX = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   main_data_reg, main_data_next;
  logic                main_err_reg, main_err_next;
  logic [DATA_W-1:0]   skid_data_reg, skid_data_next;
  logic                skid_err_reg, skid_err_next;
  logic                in_ready_reg;
  logic                in_ready_next;

  logic [DATA_W-1:0]   in_arr [N_IN];
  logic [DATA_W-1:0]   sel_data;
  logic                sel_err;
  logic                accept;
  logic                deliver;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
    assign in_arr[gi] = in_data[gi*DATA_W +: DATA_W];
  end

  // A code that matches no input index falls back to DEFAULT_IDX and is flagged.
  always_comb begin
    sel_data = in_arr[DEFAULT_IDX];
    sel_err  = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_data = in_arr[i];
        sel_err  = 1'b0;
      end
    end
  end

  assign accept  = in_valid && in_ready_reg;
  assign deliver = (state_reg != EMPTY) && out_ready;

  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    main_err_next  = main_err_reg;
    skid_data_next = skid_data_reg;
    skid_err_next  = skid_err_reg;

    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next     = ONE;
          main_data_next = sel_data;
          main_err_next  = sel_err;
        end
      end
      ONE: begin
        if (accept && !deliver) begin
          state_next     = TWO;
          skid_data_next = sel_data;
          skid_err_next  = sel_err;
        end else if (accept && deliver) begin
          main_data_next = sel_data;
          main_err_next  = sel_err;
        end else if (deliver) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (deliver) begin
          state_next     = ONE;
          main_data_next = skid_data_reg;
          main_err_next  = skid_err_reg;
        end
      end
      default: state_next = EMPTY;
    endcase

    // Flush drops every beat but leaves the stale data on the (invalid) outputs.
    if (flush) begin
      state_next     = EMPTY;
      main_data_next = main_data_reg;
      main_err_next  = main_err_reg;
    end

    in_ready_next = (state_next != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      main_data_reg <= '0;
      main_err_reg  <= 1'b0;
      skid_data_reg <= '0;
      skid_err_reg  <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      main_err_reg  <= main_err_next;
      skid_data_reg <= skid_data_next;
      skid_err_reg  <= skid_err_next;
      in_ready_reg  <= in_ready_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_data  = main_data_reg;
  assign out_err   = main_err_reg;
  assign out_valid = (state_reg != EMPTY);

endmodule
